// File: rtl/audio_pkg.sv
// Shared audio-domain types and constants for the synth mixer and I2S path.
// All blocks here run on the single audio clock.
package audio_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] pcm_t;

  localparam pcm_t VOL = 16'sh0400;

  localparam int SLOT_BITS  = 32;
  localparam int BCLK_HALF  = 1;
  localparam int FRAME_CLKS = 2 * BCLK_HALF * 2 * SLOT_BITS;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: bclk is a registered data signal, not a clock.
// fall_evt marks the clk cycle whose edge takes bclk from 1 to 0.
module i2s_bclk_gen #(
  parameter int BCLK_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_evt
);

  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [CW-1:0] div_cnt;
  logic          tc;

  assign tc       = (div_cnt == CW'(BCLK_HALF - 1));
  assign fall_evt = tc & bclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= CW'(div_cnt + 1'b1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one mono PCM word per frame, sent in both slots.
// The sample is latched at the frame wrap so mid-frame input changes are ignored.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_W    = audio_pkg::DATA_W,
  parameter int SLOT_BITS = audio_pkg::SLOT_BITS,
  parameter int BCLK_HALF = audio_pkg::BCLK_HALF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pcm_in,
  input  logic              mute,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              sample_tick
);

  localparam int POS_W = $clog2(2 * SLOT_BITS);
  localparam logic [POS_W-1:0] SLOT_P = POS_W'(SLOT_BITS);
  localparam logic [POS_W-1:0] LAST_P = POS_W'(2 * SLOT_BITS - 1);

  logic              fall_evt;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  pos_nxt;
  logic [POS_W-1:0]  s_nxt;
  logic [DATA_W-1:0] hold;
  logic              wrap;
  logic              lr_nxt;
  logic              sd_nxt;

  i2s_bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .bclk    (bclk),
    .fall_evt(fall_evt)
  );

  // s = 1..DATA_W carries hold MSB-first; s = 0 is the one-bit I2S delay
  always_comb begin
    wrap    = (pos == LAST_P);
    pos_nxt = wrap ? '0 : POS_W'(pos + 1'b1);
    lr_nxt  = (pos_nxt >= SLOT_P);
    s_nxt   = lr_nxt ? POS_W'(pos_nxt - SLOT_P) : pos_nxt;
    sd_nxt  = 1'b0;
    for (int i = 1; i <= DATA_W; i++) begin
      if (s_nxt == POS_W'(i)) sd_nxt = hold[DATA_W-i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos         <= '0;
      hold        <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= fall_evt & wrap;
      if (fall_evt) begin
        pos   <= pos_nxt;
        lrclk <= lr_nxt;
        sdata <= sd_nxt;
        if (wrap) hold <= mute ? '0 : pcm_in;
      end
    end
  end

endmodule
